// File: rtl/snake_pkg.sv
// snake_pkg: forward codes, FSM states and reversal helper
// shared by the snake step scheduler files.
package snake_pkg;

  typedef logic [1:0] fwd_t;

  localparam fwd_t FORWARD_X_UP   = 2'b00;
  localparam fwd_t FORWARD_X_DOWN = 2'b01;
  localparam fwd_t FORWARD_Y_UP   = 2'b10;
  localparam fwd_t FORWARD_Y_DOWN = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_W_START,
    S_W_BUSY,
    S_R_START,
    S_R_BUSY,
    S_PRESENT,
    S_HALT
  } state_t;

  // same axis, opposite sense
  function automatic logic is_reversal(
    input fwd_t a,
    input fwd_t b
  );
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_step_sched_if.sv
// snake_step_sched_if: control, writer/reader handshake
// and frame hand-off signals of the step scheduler.
interface snake_step_sched_if;
  import snake_pkg::*;

  logic        run;
  logic        pause;
  fwd_t        dir_in;
  logic        dir_vld;
  logic        w_en;
  fwd_t        w_forward;
  logic        w_busy;
  logic        r_en;
  logic        r_busy;
  logic        game_over;
  logic        frame_vld;
  logic        frame_rdy;
  logic        halted;
  logic        err;
  logic [15:0] step_cnt;

  modport master (
    input  run, pause, dir_in, dir_vld,
    input  w_busy, r_busy, game_over, frame_rdy,
    output w_en, w_forward, r_en, frame_vld,
    output halted, err, step_cnt
  );

  modport slave (
    output run, pause, dir_in, dir_vld,
    output w_busy, r_busy, game_over, frame_rdy,
    input  w_en, w_forward, r_en, frame_vld,
    input  halted, err, step_cnt
  );

endinterface

// File: rtl/snake_tick_div.sv
// snake_tick_div: pausable, clearable modulo-TICK_DIV
// counter with a one-cycle terminal-count pulse.
module snake_tick_div #(
  parameter int unsigned TICK_DIV = 2700000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tc = en && (cnt == LAST);

  // count enabled cycles, wrap on terminal count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr || tc)
      cnt <= '0;
    else if (en)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/snake_step_sched.sv
// snake_step_sched: tick -> write -> read -> present game step
// sequencer. Busy watchdog compiled in with SNAKE_WDT_EN.
module snake_step_sched
  import snake_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 2700000,
  parameter int unsigned WDT_CYCLES = 4096
) (
  input logic                clk,
  input logic                rst,
  snake_step_sched_if.master bus
);

  state_t state;
  state_t nxt;
  logic   tc;
  fwd_t   dir_q;
  logic   wb_q;
  logic   rb_q;
  logic   w_fall;
  logic   r_fall;
  logic   wdt_hit;

  snake_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk(clk),
    .rst(rst),
    .clr(state != S_WAIT_TICK),
    .en (state == S_WAIT_TICK && !bus.pause),
    .tc (tc)
  );

  assign w_fall = wb_q && !bus.w_busy;
  assign r_fall = rb_q && !bus.r_busy;

  assign bus.w_en      = (state == S_W_START);
  assign bus.r_en      = (state == S_R_START);
  assign bus.frame_vld = (state == S_PRESENT);
  assign bus.halted    = (state == S_HALT);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (bus.run) nxt = S_WAIT_TICK;
      S_WAIT_TICK:
        if (tc) nxt = S_W_START;
      S_W_START:
        nxt = S_W_BUSY;
      S_W_BUSY:
        if (w_fall) nxt = S_R_START;
        else if (wdt_hit) nxt = S_HALT;
      S_R_START:
        nxt = S_R_BUSY;
      S_R_BUSY:
        if (r_fall) nxt = S_PRESENT;
        else if (wdt_hit) nxt = S_HALT;
      S_PRESENT:
        if (bus.frame_rdy) begin
          if (bus.game_over) nxt = S_HALT;
          else if (bus.run) nxt = S_WAIT_TICK;
          else nxt = S_IDLE;
        end
      S_HALT:
        if (!bus.run) nxt = S_IDLE;
    endcase
  end

  // busy copies armed only in their wait state,
  // so a fall needs a rise seen there first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= 1'b0;
      rb_q <= 1'b0;
    end else begin
      wb_q <= (state == S_W_BUSY) && bus.w_busy;
      rb_q <= (state == S_R_BUSY) && bus.r_busy;
    end
  end

  // direction latch; forward issued with the w_en pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q         <= FORWARD_X_UP;
      bus.w_forward <= FORWARD_X_UP;
    end else begin
      if (bus.dir_vld &&
          !is_reversal(bus.dir_in, bus.w_forward))
        dir_q <= bus.dir_in;
      if (state == S_WAIT_TICK && tc)
        bus.w_forward <= dir_q;
    end
  end

  // completed-step counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bus.step_cnt <= '0;
    else if (state == S_PRESENT && bus.frame_rdy)
      bus.step_cnt <= bus.step_cnt + 16'd1;
  end

`ifdef SNAKE_WDT_EN
  localparam int unsigned WW = $clog2(WDT_CYCLES + 1);

  logic [WW-1:0] wdt_cnt;
  logic          in_busy;

  assign in_busy = (state == S_W_BUSY) ||
                   (state == S_R_BUSY);
  assign wdt_hit = in_busy &&
                   (wdt_cnt == WW'(WDT_CYCLES - 1));

  // busy-wait watchdog with sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_cnt <= '0;
      bus.err <= 1'b0;
    end else begin
      wdt_cnt <= in_busy ? wdt_cnt + WW'(1) : '0;
      if (in_busy && nxt == S_HALT)
        bus.err <= 1'b1;
    end
  end
`else
  assign wdt_hit = 1'b0;
  // no watchdog: err is constant low
  assign bus.err = 1'b0 & (WDT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_snake_step_sched.sv
// tb_snake_step_sched: directed and randomized checks of the
// step scheduler against a step-level reference model.
module tb_snake_step_sched;

  localparam int TD = 8;
  localparam int WD = 32;
`ifdef SNAKE_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  snake_step_sched_if bif();

  snake_step_sched #(
    .TICK_DIV(TD),
    .WDT_CYCLES(WD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif.master)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit cmp_on = 1'b0;
  bit stuck = 1'b0;
  int lat_w = 5;
  int lat_r = 5;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle 1 waiting 2 write pulse 3 writing
  //        4 read pulse 5 reading 6 presenting 7 halted
  int          ph = 0;
  int          ticks = 0;
  int          wdt = 0;
  bit          seen = 1'b0;
  bit          m_err = 1'b0;
  logic        mb;
  logic [1:0]  m_dir = 2'b00;
  logic [1:0]  m_fwd = 2'b00;
  logic [1:0]  nd;
  logic [15:0] m_steps = 16'd0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      ph = 0; ticks = 0; wdt = 0; seen = 1'b0;
      m_err = 1'b0; m_dir = 2'b00; m_fwd = 2'b00;
      m_steps = 16'd0;
    end else begin
      nd = m_dir;
      if (bif.dir_vld && ((bif.dir_in ^ m_fwd) != 2'b01))
        nd = bif.dir_in;
      case (ph)
        0: if (bif.run) begin ph = 1; ticks = 0; end
        1: if (!bif.pause) begin
             ticks++;
             if (ticks == TD) begin ph = 2; m_fwd = m_dir; end
           end
        2, 4: begin ph++; seen = 1'b0; wdt = 0; end
        3, 5: begin
          mb = (ph == 3) ? bif.w_busy : bif.r_busy;
          if (seen && !mb) ph++;
          else begin
            if (mb) seen = 1'b1;
            wdt++;
            if (WDT && wdt == WD) begin m_err = 1'b1; ph = 7; end
          end
        end
        6: if (bif.frame_rdy) begin
             m_steps++;
             ticks = 0;
             if (bif.game_over) ph = 7;
             else ph = bif.run ? 1 : 0;
           end
        7: if (!bif.run) ph = 0;
        default: ph = 0;
      endcase
      m_dir = nd;
    end
  end

  function automatic logic [31:0] outs();
    return {9'd0, bif.w_en, bif.r_en, bif.frame_vld,
            bif.halted, bif.err, bif.w_forward, bif.step_cnt};
  endfunction

  function automatic logic [31:0] exp_outs();
    return {9'd0, ph == 2, ph == 4, ph == 6, ph == 7,
            m_err, m_fwd, m_steps};
  endfunction

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      tests++;
      if (outs() !== exp_outs() || (bif.w_en && bif.r_en)) begin
        fails++;
        $display("FAIL model cyc %0d: got %h, want %h",
                 cyc, outs(), exp_outs());
      end
    end
  end

  // ---------------- writer/reader responders ----------------
  bit wp, rp;
  int wc = 0, rc = 0;
  initial begin
    bif.w_busy = 1'b0;
    bif.r_busy = 1'b0;
    forever begin
      @(negedge clk);
      wp = bif.w_en;
      rp = bif.r_en;
      @(posedge clk);
      #1;
      if (!rst) begin
        bif.w_busy = 1'b0; bif.r_busy = 1'b0; wc = 0; rc = 0;
      end else begin
        if (wp) begin bif.w_busy = 1'b1; wc = lat_w; end
        else if (bif.w_busy) begin
          if (wc > 0) wc--;
          if (wc == 0 && !stuck) bif.w_busy = 1'b0;
        end
        if (rp) begin bif.r_busy = 1'b1; rc = lat_r; end
        else if (bif.r_busy) begin
          if (rc > 0) rc--;
          if (rc == 0) bif.r_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic bit sig(int s);
    case (s)
      0: return bif.w_en;
      1: return bif.r_en;
      2: return bif.frame_vld;
      3: return bif.halted;
      4: return !bif.w_busy;
      5: return !bif.r_busy;
      6: return bif.w_busy;
      7: return bif.r_busy;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(int s, output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sig(s)) begin t = cyc; break; end
    end
    if (t < 0) begin
      tests++;
      fails++;
      $display("FAIL timeout waiting on signal %0d", s);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int t0, t1, ta, tb, tf, n;

  initial begin
    bif.run = 1'b0; bif.pause = 1'b0;
    bif.dir_in = 2'b00; bif.dir_vld = 1'b0;
    bif.game_over = 1'b0; bif.frame_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 32'd0);
    cmp_on = 1'b1;
    tick(1);
    rst = 1'b1;

    // first step: tick latency and busy handshakes
    tick(2);
    bif.run = 1'b1;
    t0 = cyc;
    wait_sig(0, t1);
    chk("run_to_w_en", t1 - (t0 + 1), 8);
    chk("first_forward", 32'(bif.w_forward), 0);
    wait_sig(6, ta);
    wait_sig(4, tf);
    wait_sig(1, tb);
    chk("r_en_after_w_fall", tb - tf, 1);
    wait_sig(7, ta);
    wait_sig(5, tf);
    wait_sig(2, tb);
    chk("frame_after_r_fall", tb - tf, 1);

    // frame stall
    repeat (10) @(negedge clk);
    chk("frame_vld_held", 32'(bif.frame_vld), 1);
    chk("step_cnt_held", 32'(bif.step_cnt), 0);
    bif.frame_rdy = 1'b1;
    @(negedge clk);
    chk("step_cnt_one", 32'(bif.step_cnt), 1);

    // reversal dropped, turn accepted
    tick(1);
    bif.dir_in = 2'b01; bif.dir_vld = 1'b1;
    tick(1);
    bif.dir_vld = 1'b0;
    wait_sig(0, t1);
    chk("reversal_dropped", 32'(bif.w_forward), 0);
    tick(1);
    bif.dir_in = 2'b10; bif.dir_vld = 1'b1;
    tick(1);
    bif.dir_vld = 1'b0;
    wait_sig(0, t1);
    chk("turn_accepted", 32'(bif.w_forward), 2);

    // pause stretches the tick wait
    wait_sig(2, ta);
    wait_sig(0, tb);
    chk("tick_period", tb - ta, 9);
    wait_sig(2, ta);
    @(posedge clk);
    #1 bif.pause = 1'b1;
    repeat (20) @(posedge clk);
    #1 bif.pause = 1'b0;
    wait_sig(0, tb);
    chk("pause_delay", tb - ta, 29);

    // game over halts
    bif.game_over = 1'b1;
    wait_sig(2, ta);
    @(negedge clk);
    chk("halted_on_game_over", 32'(bif.halted), 1);
    bif.game_over = 1'b0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (bif.w_en) n++;
    end
    chk("no_w_en_halted", n, 0);
    bif.run = 1'b0;
    @(negedge clk);
    chk("halt_release", 32'(bif.halted), 0);

    // stuck writer
    stuck = 1'b1;
    bif.run = 1'b1;
    wait_sig(0, t1);
`ifdef SNAKE_WDT_EN
    wait_sig(3, tb);
    chk("wdt_halt_time", tb - t1, 33);
    chk("wdt_err", 32'(bif.err), 1);
    bif.run = 1'b0;
    stuck = 1'b0;
    @(negedge clk);
    chk("err_sticky", 32'(bif.err), 1);
`else
    n = 0;
    repeat (60) begin
      @(negedge clk);
      if (bif.r_en || bif.halted || bif.err) n++;
    end
    chk("unbounded_wait", n, 0);
    stuck = 1'b0;
    wait_sig(1, tb);
`endif

    // reset during read
    bif.run = 1'b1;
    wait_sig(1, ta);
    wait_sig(7, ta);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_mid_step", outs(), 32'd0);
    bif.run = 1'b0;
    tick(2);
    rst = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (bif.w_en || bif.r_en || bif.frame_vld) n++;
    end
    chk("quiet_after_rst", n, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      bif.run = bif.halted ? 1'b0 : ($urandom_range(99) < 98);
      bif.pause = ($urandom_range(99) < 15);
      bif.dir_vld = ($urandom_range(99) < 20);
      bif.dir_in = 2'($urandom);
      bif.frame_rdy = 1'($urandom);
      bif.game_over = ($urandom_range(99) < 4);
      lat_w = int'($urandom_range(6, 1));
      lat_r = int'($urandom_range(6, 1));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
